// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for EX: dispatches mul/div ops, stalls EX, owns HI/LO.
// Optional macro MDU_DIV0_FAST_EN: divide-by-zero bypasses the divider.
module mdu_ctrl #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_stall,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stallreq,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_WAIT,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [63:0]   res;

  logic is_mul, is_div, is_sgn;
  logic is_mthi, is_mtlo, div0;
  logic ld_cnt, dec_cnt;
  logic cap_mul, cap_div, cap_div0;
  logic commit, wr_hi, wr_lo;

  // Decode the op code into operation classes
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_sgn  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    unique case (op)
      3'b001: begin is_mul = 1'b1; is_sgn = 1'b1; end
      3'b010: is_mul = 1'b1;
      3'b011: begin is_div = 1'b1; is_sgn = 1'b1; end
      3'b100: is_div = 1'b1;
      3'b101: is_mthi = 1'b1;
      3'b110: is_mtlo = 1'b1;
      default: ;
    endcase
  end

`ifdef MDU_DIV0_FAST_EN
  // Divide by zero resolves locally without the divider
  always_comb div0 = is_div & (op_b == 32'd0);
`else
  // Divide by zero goes through the divider like any divide
  always_comb div0 = 1'b0;
`endif

  // Next state, handshake outputs and datapath enables
  always_comb begin
    state_n     = state;
    mul_signed  = 1'b0;
    mul_ina     = 32'd0;
    mul_inb     = 32'd0;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = 32'd0;
    div_opdata2 = 32'd0;
    div_annul   = 1'b0;
    stallreq    = 1'b0;
    ld_cnt      = 1'b0;
    dec_cnt     = 1'b0;
    cap_mul     = 1'b0;
    cap_div     = 1'b0;
    cap_div0    = 1'b0;
    commit      = 1'b0;
    wr_hi       = 1'b0;
    wr_lo       = 1'b0;
    if (rst) begin
      state_n = IDLE;
    end else if (flush) begin
      state_n   = IDLE;
      div_annul = (state == DIV_WAIT);
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (is_mul) begin
              mul_signed = is_sgn;
              mul_ina    = op_a;
              mul_inb    = op_b;
              stallreq   = 1'b1;
              ld_cnt     = 1'b1;
              state_n    = MUL_WAIT;
            end else if (div0) begin
              stallreq = 1'b1;
              cap_div0 = 1'b1;
              state_n  = DONE;
            end else if (is_div) begin
              div_start   = 1'b1;
              div_signed  = is_sgn;
              div_opdata1 = op_a;
              div_opdata2 = op_b;
              stallreq    = 1'b1;
              state_n     = DIV_WAIT;
            end else if (is_mthi) begin
              wr_hi = !ex_stall;
            end else if (is_mtlo) begin
              wr_lo = !ex_stall;
            end
          end
        end
        MUL_WAIT: begin
          mul_signed = is_sgn;
          mul_ina    = op_a;
          mul_inb    = op_b;
          stallreq   = 1'b1;
          if (cnt == '0) begin
            cap_mul = 1'b1;
            state_n = DONE;
          end else begin
            dec_cnt = 1'b1;
          end
        end
        DIV_WAIT: begin
          div_start   = !div_ready;
          div_signed  = is_sgn;
          div_opdata1 = op_a;
          div_opdata2 = op_b;
          stallreq    = 1'b1;
          if (div_ready) begin
            cap_div = 1'b1;
            state_n = DONE;
          end
        end
        DONE: begin
          if (!ex_stall) begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Latency counter, result capture and HI/LO update
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      res <= 64'd0;
      hi  <= 32'd0;
      lo  <= 32'd0;
    end else begin
      if (ld_cnt)       cnt <= CW'(MUL_LATENCY - 1);
      else if (dec_cnt) cnt <= cnt - 1'b1;
      if (cap_mul)  res <= mul_result;
      if (cap_div)  res <= div_result;
      if (cap_div0) res <= {op_a, 32'hFFFF_FFFF};
      if (commit) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end
      if (wr_hi) hi <= op_a;
      if (wr_lo) lo <= op_a;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a 2-stage multiplier model and
// a hand-driven divider handshake.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, ex_stall, op_valid;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_signed, div_annul, div_ready;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result;
  logic        stallreq;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mdu_ctrl #(.MUL_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .op_valid(op_valid), .op(op), .op_a(op_a), .op_b(op_b),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start),
    .div_signed(div_signed), .div_opdata1(div_opdata1),
    .div_opdata2(div_opdata2), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready),
    .stallreq(stallreq), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  logic [63:0] ea, eb, p1, p2;
  assign ea = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
  assign eb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
  assign mul_result = p2;

  always_ff @(posedge clk) begin
    p1 <= ea * eb;
    p2 <= p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; op_valid = 1'b0;
    op = 3'd0; op_a = 32'd0; op_b = 32'd0;
    div_ready = 1'b0; div_result = 64'd0;
    nxt; nxt;
    rst = 1'b0;
    smp;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stallreq, 0);
    chk("rst_dstart", div_start, 0);
    chk("rst_mina", mul_ina, 0);
    nxt;

    // mult 0xFFFFFFFF * 2
    op_valid = 1'b1; op = 3'b001; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("mult_stall", stallreq, 1);
      chk("mult_sgn", mul_signed, 1);
      nxt;
    end
    smp;
    chk("mult_done_stall", stallreq, 0);
    nxt;
    op_valid = 1'b0;
    smp;
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    nxt;

    // multu 0xFFFFFFFF * 2
    op_valid = 1'b1; op = 3'b010;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("multu_stall", stallreq, 1);
      chk("multu_sgn", mul_signed, 0);
      nxt;
    end
    smp;
    chk("multu_done_stall", stallreq, 0);
    nxt;
    op_valid = 1'b0;
    smp;
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    nxt;

    // div -7 / 2, ready at cycle 33
    op_valid = 1'b1; op = 3'b011; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    for (int i = 0; i <= 33; i++) begin
      if (i == 33) begin
        div_ready  = 1'b1;
        div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      end
      smp;
      chk("div_start", div_start, (i < 33));
      chk("div_stall", stallreq, 1);
      chk("div_sgn", div_signed, 1);
      nxt;
    end
    div_ready = 1'b0;
    smp;
    chk("div_done_stall", stallreq, 0);
    chk("div_done_start", div_start, 0);
    nxt;
    op_valid = 1'b0;
    smp;
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    nxt;

    // divu 100 / 7 flushed at cycle 5
    op_valid = 1'b1; op = 3'b100; op_a = 32'd100; op_b = 32'd7;
    for (int i = 0; i < 5; i++) begin
      smp;
      chk("divu_start", div_start, 1);
      chk("divu_sgn", div_signed, 0);
      chk("divu_annul0", div_annul, 0);
      nxt;
    end
    flush = 1'b1;
    smp;
    chk("flush_annul", div_annul, 1);
    chk("flush_stall", stallreq, 0);
    chk("flush_start", div_start, 0);
    nxt;
    flush = 1'b0; op_valid = 1'b0;
    smp;
    chk("post_flush_annul", div_annul, 0);
    chk("post_flush_hi", hi, 32'hFFFF_FFFF);
    chk("post_flush_lo", lo, 32'hFFFF_FFFD);
    nxt;

    // mult 3 * 4 completing under ex_stall
    op_valid = 1'b1; op = 3'b001; op_a = 32'd3; op_b = 32'd4;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("exs_stall", stallreq, 1);
      nxt;
    end
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("exs_hold_stall", stallreq, 0);
      chk("exs_hold_lo", lo, 32'hFFFF_FFFD);
      nxt;
    end
    ex_stall = 1'b0;
    smp;
    chk("exs_lo_pre", lo, 32'hFFFF_FFFD);
    nxt;
    op_valid = 1'b0;
    smp;
    chk("exs_hi", hi, 32'd0);
    chk("exs_lo", lo, 32'd12);
    nxt;

    // mthi then mtlo back to back
    op_valid = 1'b1; op = 3'b101; op_a = 32'h1234_5678;
    smp;
    chk("mthi_stall", stallreq, 0);
    nxt;
    op = 3'b110; op_a = 32'd9;
    smp;
    chk("mtlo_stall", stallreq, 0);
    chk("mthi_hi", hi, 32'h1234_5678);
    nxt;
    op_valid = 1'b0;
    smp;
    chk("mtlo_lo", lo, 32'd9);
    chk("mtlo_hi", hi, 32'h1234_5678);
    nxt;

    // mthi blocked by ex_stall
    op_valid = 1'b1; op = 3'b101; op_a = 32'hDEAD_BEEF; ex_stall = 1'b1;
    smp;
    nxt;
    op_valid = 1'b0; ex_stall = 1'b0;
    smp;
    chk("mthi_exs_hi", hi, 32'h1234_5678);
    nxt;

    // unused op code
    op_valid = 1'b1; op = 3'b111; op_a = 32'hAAAA_AAAA;
    smp;
    chk("op7_stall", stallreq, 0);
    nxt;
    op_valid = 1'b0;
    smp;
    chk("op7_hi", hi, 32'h1234_5678);
    chk("op7_lo", lo, 32'd9);
    nxt;

    // div 5 / 0
    op_valid = 1'b1; op = 3'b011; op_a = 32'd5; op_b = 32'd0;
`ifdef MDU_DIV0_FAST_EN
    smp;
    chk("d0_stall", stallreq, 1);
    chk("d0_start", div_start, 0);
    nxt;
    smp;
    chk("d0_done_stall", stallreq, 0);
    chk("d0_done_start", div_start, 0);
    nxt;
`else
    smp;
    chk("d0_stall", stallreq, 1);
    chk("d0_start", div_start, 1);
    nxt;
    div_ready = 1'b1; div_result = {32'd5, 32'hFFFF_FFFF};
    smp;
    chk("d0_rdy_stall", stallreq, 1);
    chk("d0_rdy_start", div_start, 0);
    nxt;
    div_ready = 1'b0;
    smp;
    chk("d0_done_stall", stallreq, 0);
    nxt;
`endif
    op_valid = 1'b0;
    smp;
    chk("d0_hi", hi, 32'd5);
    chk("d0_lo", lo, 32'hFFFF_FFFF);
    nxt;

    // flush during MUL_WAIT
    op_valid = 1'b1; op = 3'b010; op_a = 32'd2; op_b = 32'd3;
    smp;
    nxt;
    flush = 1'b1;
    smp;
    chk("mflush_stall", stallreq, 0);
    chk("mflush_annul", div_annul, 0);
    nxt;
    flush = 1'b0; op_valid = 1'b0;
    smp;
    chk("mflush_hi", hi, 32'd5);
    chk("mflush_lo", lo, 32'hFFFF_FFFF);
    nxt;

    // reset in the middle of a divide
    op_valid = 1'b1; op = 3'b100; op_a = 32'd100; op_b = 32'd7;
    smp;
    nxt;
    smp;
    chk("rdiv_stall", stallreq, 1);
    nxt;
    rst = 1'b1; op_valid = 1'b0;
    smp;
    chk("rdiv_rst_stall", stallreq, 0);
    chk("rdiv_rst_annul", div_annul, 0);
    nxt;
    rst = 1'b0;
    smp;
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    chk("rdiv_idle_stall", stallreq, 0);
    chk("rdiv_idle_start", div_start, 0);
    nxt;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
